// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mode_sequencer
//  Purpose  : Operating-mode controller. Turns one-cycle command pulses from
//             the debouncer bank into start strobes for the RX, TX and
//             processing engines. Holds the mode until the matching engine
//             reports done. Aborts the active engine on an idle command.
//  Ports    : clk, rst (sync, active-high)
//             cmd_pc_ram / cmd_ram_pc / cmd_process / cmd_idle : command pulses
//             done_rx / done_tx / done_proc                    : engine done
//             start_rx / start_tx / start_proc / abort         : engine strobes
//             mode (00 IDLE, 01 RX, 10 TX, 11 PROC), busy, done, cmd_rej, err
//  Options  : MODE_SEQ_TIMEOUT_EN builds the per-mode watchdog. Expiry of the
//             watchdog aborts the engine and sets the sticky err flag. When the
//             macro is undefined, no counter is built and err stays 0.
//  Revision : 1.0  initial release
// ============================================================================
module mode_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_pc_ram,
    input  logic       cmd_ram_pc,
    input  logic       cmd_process,
    input  logic       cmd_idle,
    input  logic       done_rx,
    input  logic       done_tx,
    input  logic       done_proc,
    output logic       start_rx,
    output logic       start_tx,
    output logic       start_proc,
    output logic       abort,
    output logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       cmd_rej,
    output logic       err
);

    // The watchdog counter must be able to represent TIMEOUT_CYCLES-1.
    if (!((64'd1 << CNT_W) > 64'(TIMEOUT_CYCLES))) begin : g_bad_cfg
        $error("mode_sequencer: CNT_W too small for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RX   = 2'b01,
        S_TX   = 2'b10,
        S_PROC = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   start_rx_q, start_rx_d;
    logic   start_tx_q, start_tx_d;
    logic   start_proc_q, start_proc_d;
    logic   abort_q, abort_d;
    logic   done_q, done_d;
    logic   cmd_rej_q, cmd_rej_d;
    logic   busy_q, busy_d;
    logic   err_q, err_d;

    logic   w_any_start;
    logic   w_match_done;
    logic   w_expire;

    assign w_any_start = cmd_pc_ram | cmd_ram_pc | cmd_process;

    // Only the engine owning the current mode can complete it.
    always_comb begin
        w_match_done = 1'b0;
        case (state_q)
            S_RX:    w_match_done = done_rx;
            S_TX:    w_match_done = done_tx;
            S_PROC:  w_match_done = done_proc;
            default: w_match_done = 1'b0;
        endcase
    end

`ifdef MODE_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle so every entry to an active state starts
    // counting from zero; saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        start_rx_d   = 1'b0;
        start_tx_d   = 1'b0;
        start_proc_d = 1'b0;
        abort_d      = 1'b0;
        done_d       = 1'b0;
        cmd_rej_d    = 1'b0;
        err_d        = err_q;

        if (state_q == S_IDLE) begin
            // Fixed priority; losing commands are dropped without cmd_rej.
            if (cmd_pc_ram) begin
                state_d    = S_RX;
                start_rx_d = 1'b1;
                err_d      = 1'b0;
            end else if (cmd_ram_pc) begin
                state_d    = S_TX;
                start_tx_d = 1'b1;
                err_d      = 1'b0;
            end else if (cmd_process) begin
                state_d      = S_PROC;
                start_proc_d = 1'b1;
                err_d        = 1'b0;
            end
        end else begin
            // A start while busy is always rejected, even when the mode
            // completes in the same cycle; it is never queued.
            cmd_rej_d = w_any_start;
            if (w_match_done) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (cmd_idle) begin
                state_d = S_IDLE;
                abort_d = 1'b1;
            end else if (w_expire) begin
                state_d = S_IDLE;
                abort_d = 1'b1;
                err_d   = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_rx_q   <= 1'b0;
            start_tx_q   <= 1'b0;
            start_proc_q <= 1'b0;
            abort_q      <= 1'b0;
            done_q       <= 1'b0;
            cmd_rej_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef MODE_SEQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_rx_q   <= start_rx_d;
            start_tx_q   <= start_tx_d;
            start_proc_q <= start_proc_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            cmd_rej_q    <= cmd_rej_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef MODE_SEQ_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign start_rx   = start_rx_q;
    assign start_tx   = start_tx_q;
    assign start_proc = start_proc_q;
    assign abort      = abort_q;
    assign mode       = state_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_rej    = cmd_rej_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mode_sequencer
//  Purpose  : Self-checking bench for mode_sequencer. Directed scenarios with
//             literal expectations plus randomized traffic compared against a
//             behavioural model. Output vector layout used throughout:
//             [9]start_rx [8]start_tx [7]start_proc [6]abort [5]done
//             [4]cmd_rej [3]err [2]busy [1:0]mode
//  Revision : 1.0  initial release
// ============================================================================
module tb_mode_sequencer;

    localparam int c_TO = 8;
`ifdef MODE_SEQ_TIMEOUT_EN
    localparam bit c_TO_ON = 1'b1;
`else
    localparam bit c_TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_pc_ram = 1'b0, cmd_ram_pc = 1'b0, cmd_process = 1'b0, cmd_idle = 1'b0;
    logic       done_rx = 1'b0, done_tx = 1'b0, done_proc = 1'b0;
    logic       start_rx, start_tx, start_proc, abort, busy, done, cmd_rej, err;
    logic [1:0] mode;

    mode_sequencer #(
        .TIMEOUT_CYCLES(c_TO),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_pc_ram (cmd_pc_ram),
        .cmd_ram_pc (cmd_ram_pc),
        .cmd_process(cmd_process),
        .cmd_idle   (cmd_idle),
        .done_rx    (done_rx),
        .done_tx    (done_tx),
        .done_proc  (done_proc),
        .start_rx   (start_rx),
        .start_tx   (start_tx),
        .start_proc (start_proc),
        .abort      (abort),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .cmd_rej    (cmd_rej),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] exp_v;
    logic [9:0] obs_v;

    // Behavioural model: current mode number (0 idle, 1 RX, 2 TX, 3 PROC),
    // number of cycles spent in the current mode, sticky error.
    int m_mode = 0;
    int m_age  = 0;
    bit m_err  = 1'b0;

    task automatic model_reset();
        m_mode = 0;
        m_age  = 0;
        m_err  = 1'b0;
    endtask

    // cmds: [2]pc_ram [1]ram_pc [0]process ; dns: [0]rx [1]tx [2]proc
    task automatic model_step(input logic [2:0] cmds, input logic idl,
                              input logic [2:0] dns, output logic [9:0] e);
        logic [2:0] starts;
        logic       ab, dn, rej;
        int         pick;
        starts = 3'b000;
        ab = 1'b0; dn = 1'b0; rej = 1'b0;
        pick = 0;
        if (m_mode == 0) begin
            for (int i = 2; i >= 0; i--)
                if (cmds[i] && pick == 0) pick = 3 - i;
            if (pick != 0) begin
                m_mode = pick;
                m_age  = 1;
                m_err  = 1'b0;
                starts = 3'b100 >> (pick - 1);
            end
        end else begin
            rej = |cmds;
            if (dns[m_mode - 1]) begin
                dn = 1'b1; m_mode = 0;
            end else if (idl) begin
                ab = 1'b1; m_mode = 0;
            end else if (c_TO_ON && m_age >= c_TO) begin
                ab = 1'b1; m_err = 1'b1; m_mode = 0;
            end else begin
                m_age++;
            end
        end
        e = {starts, ab, dn, rej, m_err, (m_mode != 0), 2'(m_mode)};
    endtask

    // Drive one cycle of inputs (called just after a falling edge), update the
    // model, then sample the outputs 1 ns after the rising edge.
    task automatic tick(input logic [2:0] cmds, input logic idl,
                        input logic [2:0] dns, input logic r);
        {cmd_pc_ram, cmd_ram_pc, cmd_process} = cmds;
        cmd_idle = idl;
        {done_proc, done_tx, done_rx} = dns;
        rst = r;
        if (r) begin
            model_reset();
            exp_v = 10'b0;
        end else begin
            model_step(cmds, idl, dns, exp_v);
        end
        @(posedge clk);
        #1;
        obs_v = {start_rx, start_tx, start_proc, abort, done, cmd_rej, err, busy, mode};
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(3'b000, 1'b0, 3'b000, 1'b1);
        tick(3'b000, 1'b0, 3'b000, 1'b1);
        n_chk++;
        if (obs_v !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs_v, 10'b0);
        end
        tick(3'b000, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic test_basic_rx();
        repeat (3) tick(3'b000, 1'b0, 3'b000, 1'b0);
        tick(3'b100, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b1000000101) begin
            n_fail++;
            $display("FAIL rx_start: got %b expected %b", obs_v, 10'b1000000101);
        end
        repeat (13) begin
            tick(3'b000, 1'b0, 3'b000, 1'b0);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL rx_wait: got %b expected %b", obs_v, exp_v);
            end
            if (m_mode == 0) break;
        end
        if (m_mode != 0) begin
            tick(3'b000, 1'b0, 3'b001, 1'b0);
            n_chk++;
            if (obs_v !== 10'b0000100000) begin
                n_fail++;
                $display("FAIL rx_done: got %b expected %b", obs_v, 10'b0000100000);
            end
        end
        tick(3'b000, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL rx_after_done: got %b expected %b", obs_v, exp_v);
        end
    endtask

    task automatic test_priority();
        tick(3'b111, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b1000000101) begin
            n_fail++;
            $display("FAIL priority_all: got %b expected %b", obs_v, 10'b1000000101);
        end
        tick(3'b000, 1'b0, 3'b001, 1'b0);
        tick(3'b011, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0100000110) begin
            n_fail++;
            $display("FAIL priority_tx_over_proc: got %b expected %b", obs_v, 10'b0100000110);
        end
        tick(3'b000, 1'b0, 3'b010, 1'b0);
    endtask

    task automatic test_proc_reject();
        tick(3'b001, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0010000111) begin
            n_fail++;
            $display("FAIL proc_start: got %b expected %b", obs_v, 10'b0010000111);
        end
        tick(3'b010, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0000010111) begin
            n_fail++;
            $display("FAIL proc_reject: got %b expected %b", obs_v, 10'b0000010111);
        end
        tick(3'b000, 1'b0, 3'b011, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0000000111) begin
            n_fail++;
            $display("FAIL proc_ignore_other_done: got %b expected %b", obs_v, 10'b0000000111);
        end
        tick(3'b000, 1'b1, 3'b100, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0000100000) begin
            n_fail++;
            $display("FAIL proc_done_beats_idle: got %b expected %b", obs_v, 10'b0000100000);
        end
    endtask

    task automatic test_tx_abort();
        tick(3'b010, 1'b0, 3'b000, 1'b0);
        tick(3'b000, 1'b1, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0001000000) begin
            n_fail++;
            $display("FAIL tx_abort: got %b expected %b", obs_v, 10'b0001000000);
        end
        tick(3'b000, 1'b1, 3'b111, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0) begin
            n_fail++;
            $display("FAIL idle_cmd_in_idle: got %b expected %b", obs_v, 10'b0);
        end
    endtask

    task automatic test_back_to_back();
        tick(3'b100, 1'b0, 3'b000, 1'b0);
        tick(3'b010, 1'b0, 3'b001, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0000110000) begin
            n_fail++;
            $display("FAIL done_with_reject: got %b expected %b", obs_v, 10'b0000110000);
        end
        tick(3'b000, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0) begin
            n_fail++;
            $display("FAIL reject_not_queued: got %b expected %b", obs_v, 10'b0);
        end
        tick(3'b001, 1'b0, 3'b000, 1'b0);
        tick(3'b001, 1'b0, 3'b100, 1'b0);
        tick(3'b001, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0010000111) begin
            n_fail++;
            $display("FAIL restart_after_done: got %b expected %b", obs_v, 10'b0010000111);
        end
        tick(3'b000, 1'b1, 3'b000, 1'b0);
    endtask

    task automatic test_reset_mid();
        tick(3'b100, 1'b0, 3'b000, 1'b0);
        repeat (3) tick(3'b000, 1'b0, 3'b000, 1'b0);
        tick(3'b000, 1'b0, 3'b000, 1'b1);
        n_chk++;
        if (obs_v !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rx: got %b expected %b", obs_v, 10'b0);
        end
        tick(3'b010, 1'b0, 3'b000, 1'b0);
        n_chk++;
        if (obs_v !== 10'b0100000110) begin
            n_fail++;
            $display("FAIL accept_after_reset: got %b expected %b", obs_v, 10'b0100000110);
        end
        tick(3'b000, 1'b1, 3'b000, 1'b0);
    endtask

    task automatic test_timeout();
        tick(3'b100, 1'b0, 3'b000, 1'b0);
        for (int i = 2; i <= c_TO; i++) begin
            tick(3'b000, 1'b0, 3'b000, 1'b0);
            n_chk++;
            if (obs_v !== 10'b0000000101) begin
                n_fail++;
                $display("FAIL timeout_wait cycle %0d: got %b expected %b", i, obs_v, 10'b0000000101);
            end
        end
        tick(3'b000, 1'b0, 3'b000, 1'b0);
        if (c_TO_ON) begin
            n_chk++;
            if (obs_v !== 10'b0001001000) begin
                n_fail++;
                $display("FAIL timeout_expire: got %b expected %b", obs_v, 10'b0001001000);
            end
            tick(3'b001, 1'b0, 3'b000, 1'b0);
            n_chk++;
            if (obs_v !== 10'b0010000111) begin
                n_fail++;
                $display("FAIL err_cleared_on_start: got %b expected %b", obs_v, 10'b0010000111);
            end
            repeat (c_TO - 1) tick(3'b000, 1'b0, 3'b000, 1'b0);
            tick(3'b000, 1'b0, 3'b100, 1'b0);
            n_chk++;
            if (obs_v !== 10'b0000100000) begin
                n_fail++;
                $display("FAIL done_on_expiry: got %b expected %b", obs_v, 10'b0000100000);
            end
        end else begin
            repeat (12) tick(3'b000, 1'b0, 3'b000, 1'b0);
            n_chk++;
            if (obs_v !== 10'b0000000101) begin
                n_fail++;
                $display("FAIL no_watchdog_wait: got %b expected %b", obs_v, 10'b0000000101);
            end
            tick(3'b000, 1'b1, 3'b000, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [2:0] c, d;
        logic       idl, r;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++) begin
                c[b] = ($urandom_range(0, 7) == 0);
                d[b] = ($urandom_range(0, 9) == 0);
            end
            idl = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 199) == 0);
            tick(c, idl, d, r);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL random step %0d: got %b expected %b", n, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rx();
        test_priority();
        test_proc_reject();
        test_tx_abort();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
